// File: rtl/i2c_slave_regfile.sv
// SCL-clocked I2C slave fronting a byte-wide register file.
// A write transfer sets a register pointer and then bursts writes; a read transfer bursts reads until the master NACKs.
module i2c_slave_regfile #(
  parameter int         ADDR_W   = 7,
  parameter int         NUM_REGS = 8,
  parameter int         PTR_W    = 3,
  parameter logic [7:0] RST_VAL  = 8'h00
) (
  input  logic                  SCL,
  input  logic                  RST,
  input  logic [ADDR_W-1:0]     slave_addr,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic [NUM_REGS*8-1:0] regs_out,
  output logic                  wr_strobe,
  output logic [PTR_W-1:0]      wr_idx,
  output logic                  addressed
);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK
  } state_t;

  state_t                  state, state_nxt;
  logic [7:0]              shift, shift_nxt;
  logic [2:0]              bit_cnt, cnt_nxt;
  logic [PTR_W-1:0]        ptr, ptr_nxt;
  logic                    rw, rw_nxt;
  logic                    addressed_nxt;
  logic                    we;
  logic                    oe_nxt;
  logic [7:0]              in_byte;
  logic [7:0]              rd_byte;
  logic [NUM_REGS*8-1:0]   regs_q;

  assign in_byte  = {shift[6:0], sda_in};
  assign rd_byte  = regs_q[{ptr, 3'b000} +: 8];
  assign regs_out = regs_q;

  always_comb begin
    state_nxt     = state;
    shift_nxt     = shift;
    cnt_nxt       = bit_cnt;
    ptr_nxt       = ptr;
    rw_nxt        = rw;
    addressed_nxt = addressed;
    we            = 1'b0;

    if (start) begin
      state_nxt     = ADDR;
      shift_nxt     = {7'b0, sda_in};
      cnt_nxt       = 3'd1;
      addressed_nxt = 1'b0;
    end else if (stop) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ADDR: begin
          shift_nxt = in_byte;
          cnt_nxt   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (in_byte[7:8-ADDR_W] == slave_addr) begin
              state_nxt     = ADDR_ACK;
              rw_nxt        = in_byte[0];
              addressed_nxt = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        ADDR_ACK: begin
          cnt_nxt = '0;
          if (rw) begin
            state_nxt = RDATA;
            shift_nxt = rd_byte;
          end else begin
            state_nxt = PTR;
          end
        end
        PTR: begin
          shift_nxt = in_byte;
          cnt_nxt   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            ptr_nxt   = in_byte[PTR_W-1:0];
            state_nxt = PTR_ACK;
          end
        end
        PTR_ACK: begin
          cnt_nxt   = '0;
          state_nxt = WDATA;
        end
        WDATA: begin
          shift_nxt = in_byte;
          cnt_nxt   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            we        = 1'b1;
            ptr_nxt   = ptr + PTR_W'(1);
            state_nxt = WDATA_ACK;
          end
        end
        WDATA_ACK: begin
          cnt_nxt   = '0;
          state_nxt = WDATA;
        end
        RDATA: begin
          // the bit on the wire is shift[7]; consume it on each rising edge
          shift_nxt = {shift[6:0], 1'b0};
          cnt_nxt   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            ptr_nxt   = ptr + PTR_W'(1);
            state_nxt = RDATA_ACK;
          end
        end
        RDATA_ACK: begin
          cnt_nxt = '0;
          if (!sda_in) begin
            state_nxt = RDATA;
            shift_nxt = rd_byte;
          end else begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end

    if (state_nxt == IDLE) addressed_nxt = 1'b0;
  end

  always_ff @(posedge SCL or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      shift     <= '0;
      bit_cnt   <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      addressed <= 1'b0;
      wr_strobe <= 1'b0;
      wr_idx    <= '0;
      regs_q    <= {NUM_REGS{RST_VAL}};
    end else begin
      state     <= state_nxt;
      shift     <= shift_nxt;
      bit_cnt   <= cnt_nxt;
      ptr       <= ptr_nxt;
      rw        <= rw_nxt;
      addressed <= addressed_nxt;
      wr_strobe <= we;
      if (we) begin
        wr_idx                    <= ptr;
        regs_q[{ptr, 3'b000} +: 8] <= in_byte;
      end
    end
  end

  always_comb begin
    oe_nxt = 1'b0;
    case (state)
      ADDR_ACK, PTR_ACK, WDATA_ACK: oe_nxt = 1'b1;
      RDATA:                        oe_nxt = ~shift[7];
      default:                      oe_nxt = 1'b0;
    endcase
  end

  // SDA only moves while SCL is low
  always_ff @(negedge SCL or negedge RST) begin
    if (!RST) sda_oe <= 1'b0;
    else      sda_oe <= oe_nxt;
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: directed bus scenarios plus randomized transfers
// checked against an array-based register model.
module tb_i2c_slave_regfile;

  localparam int         NREG    = 8;
  localparam logic [6:0] MY_ADDR = 7'h24;

  logic              SCL = 1'b0;
  logic              RST = 1'b0;
  logic [6:0]        slave_addr = MY_ADDR;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              sda_in = 1'b1;
  logic              sda_oe;
  logic [NREG*8-1:0] regs_out;
  logic              wr_strobe;
  logic [2:0]        wr_idx;
  logic              addressed;

  int unsigned total = 0;
  int unsigned bad = 0;

  logic [7:0]  mem [NREG];
  int unsigned mptr;
  int unsigned got_idx[$];
  int unsigned exp_idx[$];
  logic [7:0]  dq[$];

  i2c_slave_regfile #(
    .ADDR_W(7),
    .NUM_REGS(NREG),
    .PTR_W(3),
    .RST_VAL(8'h00)
  ) dut (
    .SCL(SCL),
    .RST(RST),
    .slave_addr(slave_addr),
    .start(start),
    .stop(stop),
    .sda_in(sda_in),
    .sda_oe(sda_oe),
    .regs_out(regs_out),
    .wr_strobe(wr_strobe),
    .wr_idx(wr_idx),
    .addressed(addressed)
  );

  always #5 SCL = ~SCL;

  always begin
    @(posedge SCL);
    #1;
    if (wr_strobe === 1'b1) got_idx.push_back(int'(wr_idx));
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One SCL period: set inputs while SCL is low, return just after the rising edge.
  task automatic bit_cycle(input logic b, input logic st, input logic sp, output logic oe);
    @(negedge SCL);
    #1;
    oe     = sda_oe;
    sda_in = b;
    start  = st;
    stop   = sp;
    @(posedge SCL);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic with_start, output logic ack);
    logic oe;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], with_start && (i == 7), 1'b0, oe);
    bit_cycle(1'b1, 1'b0, 1'b0, oe);
    ack = oe;
  endtask

  task automatic recv_byte(input logic mnack, output logic [7:0] b, output logic oe_ack);
    logic oe;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, 1'b0, 1'b0, oe);
      b[i] = ~oe;
    end
    bit_cycle(mnack, 1'b0, 1'b0, oe);
    oe_ack = oe;
  endtask

  task automatic do_stop();
    logic oe;
    bit_cycle(1'b1, 1'b0, 1'b1, oe);
  endtask

  function automatic logic [NREG*8-1:0] model_flat();
    logic [NREG*8-1:0] r;
    for (int i = 0; i < NREG; i++) r[i*8 +: 8] = mem[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) mem[i] = 8'h00;
    mptr = 0;
  endtask

  // Address+write, pointer byte, then every byte queued in dq.
  task automatic txn_write(input logic [7:0] pbyte);
    logic ack;
    send_byte({MY_ADDR, 1'b0}, 1'b1, ack);
    chk("w_addr_ack", ack, 1);
    chk("w_addressed", addressed, 1);
    send_byte(pbyte, 1'b0, ack);
    chk("ptr_ack", ack, 1);
    mptr = pbyte % NREG;
    foreach (dq[k]) begin
      send_byte(dq[k], 1'b0, ack);
      chk("data_ack", ack, 1);
      mem[mptr] = dq[k];
      exp_idx.push_back(mptr);
      mptr = (mptr + 1) % NREG;
    end
    dq.delete();
  endtask

  task automatic txn_read(input int unsigned n);
    logic       ack;
    logic [7:0] b;
    logic       oe_ack;
    send_byte({MY_ADDR, 1'b1}, 1'b1, ack);
    chk("r_addr_ack", ack, 1);
    for (int unsigned k = 0; k < n; k++) begin
      recv_byte(k == n - 1, b, oe_ack);
      chk("rdata", b, mem[mptr]);
      chk("rd_ack_released", oe_ack, 0);
      mptr = (mptr + 1) % NREG;
    end
    chk("addressed_after_nack", addressed, 0);
  endtask

  task automatic txn_mismatch();
    logic       ack;
    logic [6:0] a;
    a = 7'($urandom_range(0, 127));
    if (a == MY_ADDR) a = a ^ 7'h01;
    send_byte({a, 1'($urandom_range(0, 1))}, 1'b1, ack);
    chk("mis_addr_ack", ack, 0);
    chk("mis_addressed", addressed, 0);
    send_byte(8'($urandom_range(0, 255)), 1'b0, ack);
    chk("mis_data_ack", ack, 0);
  endtask

  task automatic check_state(input string tag);
    int unsigned n;
    chk({tag, "_regs"}, regs_out, model_flat());
    chk({tag, "_nstrobe"}, got_idx.size(), exp_idx.size());
    n = (got_idx.size() < exp_idx.size()) ? got_idx.size() : exp_idx.size();
    for (int unsigned i = 0; i < n; i++) chk({tag, "_wr_idx"}, got_idx[i], exp_idx[i]);
    got_idx.delete();
    exp_idx.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic oe;
    logic ack;
    int unsigned kind;
    int unsigned n;

    model_reset();
    #12;
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_regs", regs_out, '0);
    chk("rst_wr_strobe", wr_strobe, 0);
    chk("rst_wr_idx", wr_idx, 0);
    chk("rst_addressed", addressed, 0);
    @(negedge SCL);
    #1;
    RST = 1'b1;

    // burst write 0xA5, 0x5A starting at register 2
    dq = '{8'hA5, 8'h5A};
    txn_write(8'h02);
    do_stop();
    chk("stop_addressed", addressed, 0);
    check_state("wr_burst");

    // pointer set, repeated START, two-byte read
    txn_write(8'h02);
    txn_read(2);
    bit_cycle(1'b1, 1'b0, 1'b0, oe);
    chk("idle_sda_oe", oe, 0);
    check_state("rd_burst");

    // foreign address is ignored
    txn_mismatch();
    do_stop();
    check_state("mismatch");

    // pointer wraps from the last register to register 0
    dq = '{8'h11, 8'h22};
    txn_write(8'h07);
    do_stop();
    check_state("wrap");

    // STOP after four data bits drops the byte, next write goes through
    txn_write(8'h05);
    for (int i = 0; i < 4; i++) bit_cycle(1'b1, 1'b0, 1'b0, oe);
    do_stop();
    check_state("abort");
    dq = '{8'h77};
    txn_write(8'h05);
    do_stop();
    check_state("after_abort");

    for (int unsigned t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 4);
      n    = $urandom_range(1, 4);
      case (kind)
        0: begin
          for (int unsigned k = 0; k < $urandom_range(0, 4); k++) dq.push_back(8'($urandom_range(0, 255)));
          txn_write(8'($urandom_range(0, 255)));
          do_stop();
        end
        1: begin
          txn_read(n);
          do_stop();
        end
        2: begin
          txn_write(8'($urandom_range(0, 255)));
          txn_read(n);
        end
        3: begin
          txn_mismatch();
          do_stop();
        end
        default: begin
          txn_write(8'($urandom_range(0, 255)));
          for (int unsigned k = 0; k < $urandom_range(1, 7); k++) bit_cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, oe);
          txn_read(n);
        end
      endcase
      check_state("rand");
    end

    // reset while the slave is pulling SDA low for a read bit
    dq = '{8'h3C};
    txn_write(8'h01);
    do_stop();
    check_state("pre_rst");
    txn_write(8'h01);
    send_byte({MY_ADDR, 1'b1}, 1'b1, ack);
    chk("rr_addr_ack", ack, 1);
    @(negedge SCL);
    #1;
    chk("rd_bit_low", sda_oe, 1);
    RST = 1'b0;
    #1;
    chk("rst_mid_sda_oe", sda_oe, 0);
    chk("rst_mid_regs", regs_out, '0);
    chk("rst_mid_addressed", addressed, 0);
    chk("rst_mid_wr_idx", wr_idx, 0);
    model_reset();
    @(negedge SCL);
    #1;
    chk("rst_hold_sda_oe", sda_oe, 0);
    RST = 1'b1;
    dq = '{8'hC3};
    txn_write(8'h06);
    do_stop();
    check_state("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
Parametrised successor to the single-byte I2C slave. It is an SCL-clocked I2C slave that fronts an internal register file of NUM_REGS bytes. A write transfer sets a register pointer and then performs burst writes with auto-increment; a read transfer performs burst reads with master ACK/NACK flow control. It sits behind an external START/STOP bus-condition detector and an open-drain SDA pad (SDA low when sda_oe=1).

Parameters:
ADDR_W, 7, slave address width (7 only; the 10-bit form is reserved)
NUM_REGS, 8, number of 8-bit registers (power of two, 2..256)
PTR_W, 3, pointer width = log2(NUM_REGS)
RST_VAL, 8'h00, reset value of every register

Ports:
SCL  in  1  bus clock; all state changes on the rising edge, sda_oe on the falling edge
RST  in  1  asynchronous active-low reset
slave_addr  in  ADDR_W  own bus address
start  in  1  START or repeated START seen; held until the next SCL rising edge
stop  in  1  STOP seen; held until the next SCL rising edge
sda_in  in  1  sampled SDA level
sda_oe  out  1  1 = pull SDA low
regs_out  out  NUM_REGS*8  flat register file contents, reg i at [8i+7:8i]
wr_strobe  out  1  one-SCL-cycle pulse when a data byte is written
wr_idx  out  PTR_W  index written, valid with wr_strobe
addressed  out  1  high from the address-match ACK until return to IDLE

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE, sda_oe=0, pointer=0, bit count=0, all registers=RST_VAL, wr_strobe=0, wr_idx=0, addressed=0.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- Rising edge with start=1, from any state:
  - Go to ADDR. Shift sda_in in as address MSB. Bit count=1. addressed=0.
  - start has priority over stop.
- Rising edge with stop=1 and start=0: go to IDLE and ignore sda_in.
- ADDR: shift 8 bits MSB first (address[ADDR_W-1:0], then R/W).
  - On the 8th bit, if the address equals slave_addr, go to ADDR_ACK.
  - Otherwise go to IDLE; no ACK is driven and the rest of the transfer is ignored.
- ADDR_ACK: sda_oe=1 on the falling edge after the 8th bit; set addressed.
  - On the 9th rising edge go to PTR if R/W=0, else RDATA.
- PTR: shift 8 bits; go to PTR_ACK.
  - Load pointer = byte[PTR_W-1:0]; ignore the upper bits.
  - ACK the byte (sda_oe=1 for the 9th bit), then go to WDATA.
- WDATA: shift 8 bits; on the 8th rising edge:
  - reg[pointer] = byte, wr_strobe=1 for that cycle, wr_idx=pointer.
  - pointer increments modulo NUM_REGS (wraps NUM_REGS-1 to 0).
  - Go to WDATA_ACK, ACK, then return to WDATA.
- RDATA:
  - Load the shift register from reg[pointer] on the rising edge that enters RDATA.
  - On each falling edge, sda_oe = ~bit (MSB first); a 0 bit drives low, a 1 bit releases.
  - After the 8th bit, pointer increments with wrap; go to RDATA_ACK. sda_oe=0 on that falling edge.
- RDATA_ACK: sample the master's ACK on the 9th rising edge.
  - sda_in=0: load the next byte and go to RDATA.
  - sda_in=1 (NACK): go to IDLE; sda_oe stays 0.
- sda_oe changes only on SCL falling edges. It is 0 in IDLE, ADDR, PTR, WDATA and RDATA_ACK.
- Repeated START mid-byte aborts the byte; a partially shifted write is discarded and the pointer is kept. Pointer persists across transfers (set-pointer-then-read pattern).
- STOP mid-byte discards the partial byte. A completed byte is already committed even if its ACK phase is cut short.
- Reset mid-transfer releases SDA immediately (sda_oe=0, asynchronous).

Test Plan:
- Write 0x48 with slave_addr=0x24: START, 0x48, ptr 0x02, data 0xA5, 0x5A, STOP -> ACK on all 3 bytes; reg2=A5, reg3=5A; wr_strobe twice with wr_idx 2 then 3.
- Pointer-set then repeated-START read: START 0x48, ptr 0x02, rSTART 0x49, read 2 bytes (ACK then NACK) -> SDA shows A5 then 5A; sda_oe=0 after NACK; state IDLE.
- Address mismatch, START 0x4A -> sda_oe stays 0 through the 9th bit; no register changes; addressed=0.
- Wrap: ptr 0x07, write 0x11, 0x22 -> reg7=11, reg0=22, wr_idx 7 then 0.
- Abort: STOP after 4 data bits of a write -> register unchanged, wr_strobe never pulses; a subsequent write proceeds normally.
- Reset during a read bit driving low -> sda_oe=0 at once; regs_out = all RST_VAL.
